// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: owns the PC, fetches over a req/ready handshake and
// issues decoded IR fields to the control unit. Optional perf counters: IF_PERF_CNT_EN.
module instr_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [5:0]  ILLEGAL_OP = 6'b111111
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  input  logic        stall,
  input  logic        jump,
  output logic        instr_valid,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [15:0] imm,
  output logic [31:0] pc,
  output logic        halted,
  output logic [31:0] retired_cnt,
  output logic [31:0] stall_cnt
);

  typedef enum logic [1:0] {S_RST, S_FETCH, S_ISSUE, S_HALT} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] pc_plus4;
  logic        illegal;

  assign pc_plus4 = pc_q + 32'd4;
  assign illegal  = (ir_q[31:26] == ILLEGAL_OP);

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    halted      = 1'b0;
    unique case (state_q)
      S_RST: state_d = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_d    = imem_rdata;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        instr_valid = 1'b1;
        if (illegal) begin
          state_d = S_HALT;
        end else if (!stall) begin
          // J-type target keeps the region bits of the sequential successor.
          pc_d    = jump ? {pc_plus4[31:28], ir_q[25:0], 2'b00} : pc_plus4;
          state_d = S_FETCH;
        end
      end
      S_HALT: halted = 1'b1;
      default: state_d = S_RST;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RST;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign opcode    = ir_q[31:26];
  assign rs        = ir_q[25:21];
  assign rt        = ir_q[20:16];
  assign rd        = ir_q[15:11];
  assign imm       = ir_q[15:0];

`ifdef IF_PERF_CNT_EN
  logic        retire, stall_cycle;
  logic [31:0] retired_q, stall_q;

  assign retire      = (state_q == S_ISSUE) && !illegal && !stall;
  assign stall_cycle = (state_q == S_ISSUE) && !illegal && stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_q <= '0;
      stall_q   <= '0;
    end else begin
      if (retire)      retired_q <= retired_q + 32'd1;
      if (stall_cycle) stall_q   <= stall_q + 32'd1;
    end
  end

  assign retired_cnt = retired_q;
  assign stall_cnt   = stall_q;
`else
  assign retired_cnt = 32'h0;
  assign stall_cnt   = 32'h0;
`endif

endmodule
